// File: rtl/cam_req_arbiter.sv
// Round-robin WR/RD/SR arbiter that sequences one cam operation at a time; grant is same-cycle.
// Latency: grant->cam enable 1 cycle, grant->resp_valid_o 2+CAM_LAT; resp held until resp_ready_i, no grants meanwhile.
module cam_req_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CAM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_index_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  wr_gnt_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_index_i,
    output logic                  rd_gnt_o,
    input  logic                  sr_req_i,
    input  logic [WIDTH-1:0]      sr_data_i,
    output logic                  sr_gnt_o,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [1:0]            resp_op_o,
    output logic                  resp_hit_o,
    output logic [WIDTH-1:0]      resp_data_o,
    output logic [ADDR_WIDTH-1:0] resp_index_o,
    output logic                  busy_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_WR = 2'd0, OP_RD = 2'd1, OP_SR = 2'd2} op_t;

    localparam int CW = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    state_t                state_q;
    op_t                   op_q;
    op_t                   last_q;
    op_t                   win_d;
    logic                  win_vld_d;
    logic                  gnt_en_d;
    logic [CW-1:0]         cnt_q;

    logic                  cam_we_q;
    logic                  cam_re_q;
    logic                  cam_se_q;
    logic [ADDR_WIDTH-1:0] cam_wi_q;
    logic [WIDTH-1:0]      cam_wd_q;
    logic [ADDR_WIDTH-1:0] cam_ri_q;
    logic [WIDTH-1:0]      cam_sd_q;

    logic                  resp_valid_q;
    logic [1:0]            resp_op_q;
    logic                  resp_hit_q;
    logic [WIDTH-1:0]      resp_data_q;
    logic [ADDR_WIDTH-1:0] resp_index_q;

    // Search order starts just after the last granted requester (WR->RD->SR->WR).
    always_comb begin
        win_vld_d = wr_req_i | rd_req_i | sr_req_i;
        win_d     = OP_WR;
        case (last_q)
            OP_WR:   win_d = rd_req_i ? OP_RD : (sr_req_i ? OP_SR : OP_WR);
            OP_RD:   win_d = sr_req_i ? OP_SR : (wr_req_i ? OP_WR : OP_RD);
            default: win_d = wr_req_i ? OP_WR : (rd_req_i ? OP_RD : OP_SR);
        endcase
    end

    assign gnt_en_d = rst_i && (state_q == IDLE) && win_vld_d;
    assign wr_gnt_o = gnt_en_d && (win_d == OP_WR);
    assign rd_gnt_o = gnt_en_d && (win_d == OP_RD);
    assign sr_gnt_o = gnt_en_d && (win_d == OP_SR);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            op_q         <= OP_WR;
            last_q       <= OP_SR;
            cnt_q        <= '0;
            cam_we_q     <= 1'b0;
            cam_re_q     <= 1'b0;
            cam_se_q     <= 1'b0;
            cam_wi_q     <= '0;
            cam_wd_q     <= '0;
            cam_ri_q     <= '0;
            cam_sd_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_op_q    <= 2'b00;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_index_q <= '0;
        end else begin
            cam_we_q <= 1'b0;
            cam_re_q <= 1'b0;
            cam_se_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        op_q    <= win_d;
                        last_q  <= win_d;
                        state_q <= ISSUE;
                        case (win_d)
                            OP_WR: begin
                                cam_we_q <= 1'b1;
                                cam_wi_q <= wr_index_i;
                                cam_wd_q <= wr_data_i;
                            end
                            OP_RD: begin
                                cam_re_q <= 1'b1;
                                cam_ri_q <= rd_index_i;
                            end
                            default: begin
                                cam_se_q <= 1'b1;
                                cam_sd_q <= sr_data_i;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (op_q == OP_WR) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(CAM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        if (op_q == OP_RD) begin
                            resp_op_q    <= 2'b01;
                            resp_hit_q   <= cam_read_valid_i;
                            resp_data_q  <= cam_read_value_i;
                            resp_index_q <= '0;
                        end else begin
                            resp_op_q    <= 2'b10;
                            resp_hit_q   <= cam_search_valid_i;
                            resp_data_q  <= '0;
                            resp_index_q <= cam_search_index_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o              = (state_q != IDLE);
    assign cam_write_enable_o  = cam_we_q;
    assign cam_write_index_o   = cam_wi_q;
    assign cam_write_data_o    = cam_wd_q;
    assign cam_read_enable_o   = cam_re_q;
    assign cam_read_index_o    = cam_ri_q;
    assign cam_search_enable_o = cam_se_q;
    assign cam_search_data_o   = cam_sd_q;
    assign resp_valid_o        = resp_valid_q;
    assign resp_op_o           = resp_op_q;
    assign resp_hit_o          = resp_hit_q;
    assign resp_data_o         = resp_data_q;
    assign resp_index_o        = resp_index_q;

    a_one_enable: assert property (@(posedge clk_i) disable iff (!rst_i)
        $onehot0({cam_we_q, cam_re_q, cam_se_q}));
    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_i)
        $onehot0({wr_gnt_o, rd_gnt_o, sr_gnt_o}));

endmodule
